// File: rtl/load_writeback_unit.sv
// load_writeback_unit
//   Write-back stage feeding the register file write port. Selects the ALU
//   result, PC+4 or load data, and aligns and extends load data. A load issues
//   a one-cycle memory request and then stalls the front end until the data
//   arrives or a timeout expires. The stall also ends early on a load fault.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   instr_valid       current instruction valid
//   reg_write_in      decoder write enable for rd
//   wb_sel            00 ALU, 01 MEM, 10 PC+4, 11 ALU
//   funct3            load type (LB/LH/LW/LBU/LHU)
//   rd                destination register
//   alu_result        ALU output, also the load address
//   pc_plus4          link value for JAL/JALR
//   dmem_rvalid/rdata memory response
//   dmem_req/addr     one-cycle load request and word-aligned address
//   stall             hold PC and instruction
//   write_data/write_register/reg_write  register file write port
//   load_fault        one-cycle pulse on misaligned/illegal load or timeout
module load_writeback_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_W     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic                  reg_write_in,
  input  logic [1:0]            wb_sel,
  input  logic [2:0]            funct3,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  dmem_req,
  output logic [XLEN-1:0]       dmem_addr,
  output logic                  stall,
  output logic [XLEN-1:0]       write_data,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic                  reg_write,
  output logic                  load_fault
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              off_q, off_d;

  logic                    is_load;
  logic                    illegal;
  logic                    misaligned;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [XLEN-1:0]         load_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign is_load    = instr_valid && (wb_sel == 2'b01);
  assign illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  // LH/LHU share funct3[1:0]==01; LW is the only 010 encoding.
  assign misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                      ((funct3 == 3'b010) && (alu_result[1:0] != 2'b00));

  assign byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      3'b001:  load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_d           = rd_q;
    f3_d           = f3_q;
    off_d          = off_q;
    dmem_req       = 1'b0;
    dmem_addr      = '0;
    stall          = 1'b0;
    write_data     = '0;
    write_register = '0;
    reg_write      = 1'b0;
    load_fault     = 1'b0;

    // Outputs stay at zero for as long as reset is held, not just at the edge.
    if (rst) begin
      dmem_addr = {alu_result[XLEN-1:2], 2'b00};
      unique case (state_q)
        IDLE: begin
          if (is_load) begin
            if (illegal || misaligned) begin
              load_fault = 1'b1;
            end else begin
              dmem_req = 1'b1;
              stall    = 1'b1;
              rd_d     = rd;
              f3_d     = funct3;
              off_d    = alu_result[1:0];
              cnt_d    = '0;
              state_d  = WAIT;
            end
          end else if (instr_valid) begin
            reg_write      = reg_write_in && (rd != '0);
            write_register = rd;
            write_data     = (wb_sel == 2'b10) ? pc_plus4 : alu_result;
          end
        end
        WAIT: begin
          write_register = rd_q;
          // A response in the timeout cycle still retires the load.
          if (dmem_rvalid) begin
            reg_write  = (rd_q != '0);
            write_data = load_ext;
            state_d    = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            load_fault = 1'b1;
            state_d    = IDLE;
          end else begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
module tb_load_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        reg_write_in;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        stall;
  logic [31:0] write_data;
  logic [4:0]  write_register;
  logic        reg_write;
  logic        load_fault;

  typedef struct {
    bit          is_fault;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  load_writeback_unit #(
    .XLEN(32),
    .REG_ADDR_W(5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .reg_write_in(reg_write_in),
    .wb_sel(wb_sel), .funct3(funct3), .rd(rd), .alu_result(alu_result),
    .pc_plus4(pc_plus4), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .stall(stall),
    .write_data(write_data), .write_register(write_register),
    .reg_write(reg_write), .load_fault(load_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write or fault the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (reg_write === 1'b1 || load_fault === 1'b1)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {reg_write, load_fault, write_register, write_data}, '0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_kind", {reg_write, load_fault}, e.is_fault ? 2'b01 : 2'b10);
        if (!e.is_fault) begin
          chk("out_rd", write_register, e.rd);
          chk("out_data", write_data, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    instr_valid = 1'b0;
    wb_sel      = 2'b00;
    dmem_rvalid = 1'b0;
  endtask

  task automatic non_load(input [1:0] sel, input [4:0] r, input [31:0] alu, input [31:0] pc4,
                          input bit we, input [31:0] exp_data);
    cyc();
    instr_valid = 1'b1; wb_sel = sel; rd = r; alu_result = alu; pc_plus4 = pc4;
    reg_write_in = we; dmem_rvalid = 1'b0;
    if (we && r != 5'd0) q.push_back('{1'b0, r, exp_data});
    @(negedge clk);
    chk("nl_stall_req", {stall, dmem_req}, 2'b00);
  endtask

  task automatic do_load(input [2:0] f3, input [31:0] addr, input [31:0] rdata, input [4:0] r,
                         input int unsigned waits, input bit timeout, input [31:0] exp_data);
    int unsigned stalls;
    bit          extra_req;
    stalls    = 0;
    extra_req = 1'b0;
    cyc();
    instr_valid = 1'b1; wb_sel = 2'b01; funct3 = f3; rd = r; alu_result = addr;
    dmem_rdata = rdata; dmem_rvalid = 1'b0; reg_write_in = 1'b1;
    @(negedge clk);
    chk("ld_req", dmem_req, 1'b1);
    chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
    if (stall) stalls++;
    for (int unsigned i = 0; i < waits; i++) begin
      cyc();
      @(negedge clk);
      if (stall) stalls++;
      if (dmem_req) extra_req = 1'b1;
    end
    cyc();
    if (timeout) q.push_back('{1'b1, 5'd0, 32'd0});
    else begin
      dmem_rvalid = 1'b1;
      if (r != 5'd0) q.push_back('{1'b0, r, exp_data});
    end
    @(negedge clk);
    chk("ld_retire_stall", stall, 1'b0);
    chk("ld_stall_cycles", stalls, waits + 1);
    chk("ld_single_req", extra_req, 1'b0);
    cyc();
    idle_in();
  endtask

  task automatic bad_load(input [2:0] f3, input [31:0] addr);
    cyc();
    instr_valid = 1'b1; wb_sel = 2'b01; funct3 = f3; rd = 5'd9; alu_result = addr;
    reg_write_in = 1'b1; dmem_rvalid = 1'b0;
    q.push_back('{1'b1, 5'd0, 32'd0});
    @(negedge clk);
    chk("bad_req_stall", {dmem_req, stall, reg_write}, 3'b000);
    cyc();
    idle_in();
    @(negedge clk);
    chk("bad_stays_idle", {stall, dmem_req}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_in();
    reg_write_in = 1'b0; funct3 = 3'b000; rd = 5'd0;
    alu_result = 32'd0; pc_plus4 = 32'd0; dmem_rdata = 32'd0;

    // Outputs must be forced low under reset even with a live instruction.
    cyc();
    instr_valid = 1'b1; wb_sel = 2'b00; rd = 5'd3; alu_result = 32'hDEAD_BEEF; reg_write_in = 1'b1;
    @(negedge clk);
    chk("rst_ctl", {dmem_req, stall, reg_write, load_fault}, 4'b0000);
    chk("rst_data", write_data, 32'd0);
    chk("rst_addr", {write_register, dmem_addr}, 37'd0);
    cyc();
    idle_in();
    rst = 1'b1;

    non_load(2'b00, 5'd5, 32'h0000_1234, 32'h0,       1'b1, 32'h0000_1234);
    non_load(2'b10, 5'd1, 32'hAAAA_0000, 32'h104,     1'b1, 32'h0000_0104);
    non_load(2'b10, 5'd0, 32'hAAAA_0000, 32'h104,     1'b1, 32'h0);
    chk("rd0_no_write", reg_write, 1'b0);
    non_load(2'b11, 5'd7, 32'h0000_0055, 32'h200,     1'b1, 32'h0000_0055);
    non_load(2'b00, 5'd8, 32'h0000_0077, 32'h0,       1'b0, 32'h0);
    cyc();
    idle_in();

    do_load(3'b000, 32'h0000_1003, 32'h80FF_0000, 5'd10, 3,  1'b0, 32'hFFFF_FF80);
    do_load(3'b100, 32'h0000_1003, 32'h80FF_0000, 5'd11, 3,  1'b0, 32'h0000_0080);
    do_load(3'b000, 32'h0000_1001, 32'h0000_7F00, 5'd12, 1,  1'b0, 32'h0000_007F);
    do_load(3'b001, 32'h0000_2002, 32'h8001_7F00, 5'd13, 2,  1'b0, 32'hFFFF_8001);
    do_load(3'b101, 32'h0000_2000, 32'h1234_F00D, 5'd14, 0,  1'b0, 32'h0000_F00D);
    do_load(3'b010, 32'h0000_3000, 32'hCAFE_BABE, 5'd15, 0,  1'b0, 32'hCAFE_BABE);
    do_load(3'b010, 32'h0000_3004, 32'h1111_2222, 5'd0,  2,  1'b0, 32'h0);

    bad_load(3'b001, 32'h0000_0001);
    bad_load(3'b010, 32'h0000_0002);
    bad_load(3'b011, 32'h0000_0000);
    bad_load(3'b101, 32'h0000_0003);

    do_load(3'b010, 32'h0000_4000, 32'h5555_AAAA, 5'd16, 15, 1'b1, 32'h0);
    // A response while idle must be ignored.
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("idle_rvalid_ignored", {stall, reg_write, load_fault}, 3'b000);
    cyc();
    idle_in();
    do_load(3'b010, 32'h0000_4000, 32'h5555_AAAA, 5'd17, 15, 1'b0, 32'h5555_AAAA);

    // Reset in the middle of a wait, then a late response after release.
    cyc();
    instr_valid = 1'b1; wb_sel = 2'b01; funct3 = 3'b010; rd = 5'd18;
    alu_result = 32'h0000_5000; dmem_rdata = 32'h9999_9999; reg_write_in = 1'b1;
    @(negedge clk);
    chk("mid_req", dmem_req, 1'b1);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {dmem_req, stall, reg_write, load_fault}, 4'b0000);
    chk("mid_rst_data", {write_register, write_data, dmem_addr}, 69'd0);
    idle_in();
    cyc();
    cyc();
    rst = 1'b1;
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", {stall, reg_write, load_fault, dmem_req}, 4'b0000);
    cyc();
    idle_in();

    cyc();
    cyc();
    chk("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
